// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-cache memory arbiter: width defaults,
// FSM state encoding and the owner identifier.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_WAIT  = 3'd2,
    I_ISSUE = 3'd3,
    I_WAIT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared block memory between a data cache (read/write) and
// an instruction cache (read only). One transaction at a time:
// IDLE -> x_ISSUE -> x_WAIT -> DONE -> IDLE.
//
// Handshake: a cache holds its request (read/write) and address stable while
// its busywait is high. busywait drops for exactly the DONE cycle of that
// cache's own transaction; at that point the read data register is valid.
// The memory side sees strobes held from ISSUE through WAIT; the memory
// raises m_busywait to accept and lowers it when the block is ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_busywait,
  output state_t            dbg_state
);

  state_t state, state_nxt;
  owner_t owner, last_grant;
  logic   lat_write;
  logic   d_req;
  logic   grant_d, grant_i, capture;

  assign d_req     = d_read | d_write;
  assign dbg_state = state;

  // Next-state, grant decision and state-decoded memory strobes.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    capture   = 1'b0;
    m_read    = 1'b0;
    m_write   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not own the last transaction wins.
        grant_d = d_req && (!i_read || last_grant == OWN_I);
        grant_i = i_read && !grant_d;
        if (grant_d)      state_nxt = D_ISSUE;
        else if (grant_i) state_nxt = I_ISSUE;
      end
      D_ISSUE, I_ISSUE: begin
        m_read  = !lat_write;
        m_write = lat_write;
        if (m_busywait) state_nxt = (state == D_ISSUE) ? D_WAIT : I_WAIT;
      end
      D_WAIT, I_WAIT: begin
        m_read  = !lat_write;
        m_write = lat_write;
        if (!m_busywait) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus owner/alternation bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_D;
      last_grant <= OWN_I;
    end else begin
      state <= state_nxt;
      if (grant_d)      owner <= OWN_D;
      else if (grant_i) owner <= OWN_I;
      if (state == DONE) last_grant <= owner;
    end
  end

  // Transaction latches that drive the memory address/data bus directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write   <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else if (grant_d) begin
      lat_write   <= d_write;  // read+write together is a write
      m_address   <= d_address;
      m_writedata <= d_writedata;
    end else if (grant_i) begin
      lat_write   <= 1'b0;
      m_address   <= i_address;
      m_writedata <= '0;
    end
  end

  // Read-data capture; a requester that withdrew mid-transaction gets nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_readdata <= '0;
      i_readdata <= '0;
    end else if (capture && !lat_write) begin
      if (owner == OWN_D && d_read) d_readdata <= m_readdata;
      if (owner == OWN_I && i_read) i_readdata <= m_readdata;
    end
  end

  // Stall each cache unless its own transaction is in DONE.
  assign d_busywait = d_req  && !(state == DONE && owner == OWN_D);
  assign i_busywait = i_read && !(state == DONE && owner == OWN_I);

endmodule
